pulse_debouncer: RTL and testbench

- Upstream conditioning stage for the mod-3 input-pulse counter FSM.
- Takes a raw, asynchronous, bouncy push-button/switch level and produces clean, glitch-free outputs for the counter's `in` port:
  - a synchronized debounced level;
  - a single-cycle pulse per accepted rising edge.
- Guarantees the counter sees exactly one qualified event per physical press.

---
 rtl/pulse_debouncer.sv | 118 +++++++++++
 tb/tb_pulse_debouncer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_debouncer.sv
// pulse_debouncer: conditions a raw, bouncy, asynchronous push-button level for the
// mod-3 pulse counter. It produces a debounced level and one strobe per accepted press.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive synchronized samples at the new level needed to accept a
//                     transition (legal range 2 .. 2**CNT_W)
//   CNT_W           - width of the stability counter
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   in_i    - raw external level, asynchronous to clk_i, may bounce
//   level_o - debounced level (registered)
//   pulse_o - one-cycle strobe per accepted rising edge (registered); feeds counter input
//   busy_o  - high while a candidate transition is being qualified

module pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic level_o,
  output logic pulse_o,
  output logic busy_o
);

  // Terminal count; DEBOUNCE_CYCLES <= 2**CNT_W guarantees it fits, so cnt_q never wraps.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRiseWait,
    StHigh,
    StFallWait
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             sync_q;
  logic             level_q;
  logic             pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      // Two-flop synchronizer; only sync_q is allowed to influence the FSM.
      sync1_q <= in_i;
      sync_q  <= sync1_q;
      // Strobe lasts one cycle unless re-armed below.
      pulse_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (sync_q) begin
            state_q <= StRiseWait;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        StRiseWait: begin
          if (!sync_q) begin
            // Glitch: fall back to the stable low state and start over.
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHigh: begin
          if (!sync_q) begin
            state_q <= StFallWait;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        StFallWait: begin
          if (sync_q) begin
            // Bounce on release: stay high and never re-pulse.
            state_q <= StHigh;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign busy_o  = (state_q == StRiseWait) || (state_q == StFallWait);

endmodule

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer with a cycle-indexed scoreboard of expected outputs.
module tb_pulse_debouncer;

  logic clk;
  logic rst_n;
  logic in_raw;
  logic level;
  logic pulse;
  logic busy;

  pulse_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .in_i   (in_raw),
    .level_o(level),
    .pulse_o(pulse),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    at;
    logic  l;
    logic  p;
    logic  b;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   pulse_cnt;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic l, input logic p, input logic b);
    compare(tag, 32'({level, pulse, busy}), 32'({l, p, b}));
  endtask

  // Expected {level, pulse, busy} after edge number 'at'; kept sorted by cycle.
  function automatic void expect_at(input int at, input logic l, input logic p, input logic b,
                                    input string tag);
    exp_t e;
    int   i;
    e.at  = at;
    e.l   = l;
    e.p   = p;
    e.b   = b;
    e.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (pulse === 1'b1) pulse_cnt++;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) compare({e.tag, " late"}, 32'(cyc), 32'(e.at));
      else            check_now($sformatf("%s@%0d", e.tag, cyc), e.l, e.p, e.b);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Clean press from stable low; in rises just before edge base, held for n cycles.
  task automatic expect_press(input int base, input int n, input string tag);
    for (int k = 0; k < n; k++)
      expect_at(base + k, k >= 5, k == 5, k >= 2 && k <= 4, tag);
  endtask

  // Reset released just after edge rel with in held high: synchronizer refill adds 2 edges.
  task automatic expect_after_reset(input int rel, input string tag);
    for (int k = 1; k <= 12; k++)
      expect_at(rel + k, k >= 6, k == 6, k >= 3 && k <= 5, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    cyc       = 0;
    n_cmp     = 0;
    n_err     = 0;
    pulse_cnt = 0;
    rst_n     = 1'b0;
    in_raw    = 1'b0;
    #2;
    check_now("reset", 1'b0, 1'b0, 1'b0);
    expect_at(1, 1'b0, 1'b0, 1'b0, "reset_hold");
    expect_at(2, 1'b0, 1'b0, 1'b0, "reset_hold");
    ticks(2);
    rst_n = 1'b1;
    ticks(3);

    // Clean press held 20 cycles: one pulse only, then clean release.
    base   = cyc + 1;
    in_raw = 1'b1;
    expect_press(base, 20, "press");
    ticks(20);
    base   = cyc + 1;
    in_raw = 1'b0;
    for (int k = 0; k < 10; k++) expect_at(base + k, k < 5, 1'b0, k >= 2 && k <= 4, "release");
    ticks(10);

    // Bounce on press: 3 high, 2 low, 2 high, low; never accepted.
    base = cyc + 1;
    for (int k = 0; k <= 12; k++)
      expect_at(base + k, 1'b0, 1'b0, (k >= 2 && k <= 4) || k == 7 || k == 8, "bounce");
    in_raw = 1'b1;
    ticks(3);
    in_raw = 1'b0;
    ticks(2);
    in_raw = 1'b1;
    ticks(2);
    in_raw = 1'b0;
    ticks(6);

    // Release bounce from HIGH: 0,1,0 one-cycle segments then held low.
    in_raw = 1'b1;
    ticks(8);
    base = cyc + 1;
    for (int k = 0; k <= 10; k++)
      expect_at(base + k, k < 7, 1'b0, k == 2 || (k >= 4 && k <= 6), "rel_bounce");
    in_raw = 1'b0;
    ticks(1);
    in_raw = 1'b1;
    ticks(1);
    in_raw = 1'b0;
    ticks(9);

    // Three presses separated by 10 low cycles: exactly three pulses.
    pulse_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      base   = cyc + 1;
      in_raw = 1'b1;
      expect_at(base + 5, 1'b1, 1'b1, 1'b0, "triple_pulse");
      expect_at(base + 6, 1'b1, 1'b0, 1'b0, "triple_clear");
      ticks(8);
      in_raw = 1'b0;
      ticks(10);
    end
    compare("triple_count", 32'(pulse_cnt), 32'd3);

    // Async reset while in RISE_WAIT with cnt=2.
    base   = cyc + 1;
    in_raw = 1'b1;
    ticks(4);
    check_now("rw_cnt2", 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst", 1'b0, 1'b0, 1'b0);
    expect_at(cyc + 1, 1'b0, 1'b0, 1'b0, "in_reset");
    expect_at(cyc + 2, 1'b0, 1'b0, 1'b0, "in_reset");
    ticks(2);
    rst_n     = 1'b1;
    pulse_cnt = 0;
    expect_after_reset(cyc, "post_rst");
    ticks(16);
    compare("post_rst_count", 32'(pulse_cnt), 32'd1);

    // Drop to low, then press during reset and release with in already high.
    in_raw = 1'b0;
    ticks(10);
    #2;
    rst_n  = 1'b0;
    in_raw = 1'b1;
    for (int k = 1; k <= 3; k++) expect_at(cyc + k, 1'b0, 1'b0, 1'b0, "press_in_rst");
    ticks(3);
    rst_n     = 1'b1;
    pulse_cnt = 0;
    expect_after_reset(cyc, "rel_high");
    ticks(20);
    compare("rel_high_count", 32'(pulse_cnt), 32'd1);
    compare("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
